tt_islam_ihfaz_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the NAND gate: it synchronises raw pad inputs (ui_in bits), debounces each one, and drives the clean levels that feed the gate's A/B operands. It also emits single-cycle rise/fall pulses per channel and a saturating glitch counter for bring-up diagnostics.

---
 rtl/tt_islam_ihfaz_debounce.sv | 112 +++++++++++
 tb/tb_tt_islam_ihfaz_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_islam_ihfaz_debounce.sv
`default_nettype none
// ============================================================================
// tt_islam_ihfaz_debounce : sync + debounce of raw pad inputs feeding the NAND
// Revision 1.0 : initial release
// ============================================================================
module tt_islam_ihfaz_debounce #(
  parameter int N         = 2,
  parameter int DEBOUNCE  = 1000,
  parameter int CNT_W     = 16,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] clean_out,
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse,
  output logic         settled,
  output logic [7:0]   glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [N-1:0]     RST_VEC  = {N{RESET_VAL}};

  logic [N-1:0]     sync1_q, sync1_d;
  logic [N-1:0]     s_q, s_d;
  logic [N-1:0]     clean_q, clean_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     abort;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             settled_q, settled_d;
  logic [7:0]       glitch_q, glitch_d;

  always_comb begin
    sync1_d   = sync1_q;
    s_d       = s_q;
    clean_d   = clean_q;
    rise_d    = '0;
    fall_d    = '0;
    abort     = '0;
    settled_d = settled_q;
    glitch_d  = glitch_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (ena) begin
      sync1_d   = raw_in;
      s_d       = sync1_q;
      settled_d = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (s_q[i] != clean_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = s_q[i];
            cnt_d[i]   = '0;
            rise_d[i]  = s_q[i];
            fall_d[i]  = ~s_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
          abort[i] = (cnt_q[i] != '0);
        end
        // settled looks at next-state so it rises together with a flip
        if ((cnt_d[i] != '0) || (s_d[i] != clean_d[i])) begin
          settled_d = 1'b0;
        end
        if (abort[i] && (glitch_d != 8'hFF)) begin
          glitch_d = glitch_d + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= RST_VEC;
      s_q       <= RST_VEC;
      clean_q   <= RST_VEC;
      rise_q    <= '0;
      fall_q    <= '0;
      settled_q <= 1'b1;
      glitch_q  <= 8'd0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      settled_q <= settled_d;
      glitch_q  <= glitch_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign settled    = settled_q;
  assign glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_islam_ihfaz_debounce.sv
`default_nettype none
// ============================================================================
// tb_tt_islam_ihfaz_debounce : directed self-checking bench for the debouncer
// Revision 1.0 : initial release
// ============================================================================
module tb_tt_islam_ihfaz_debounce;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena;
  logic [1:0] raw_in, clean_out, rise_pulse, fall_pulse;
  logic       settled;
  logic [7:0] glitch_cnt;

  logic       rst1_n, ena1;
  logic [1:0] raw1, clean1, rise1, fall1;
  logic       settled1;
  logic [7:0] glitch1;

  tt_islam_ihfaz_debounce #(.N(2), .DEBOUNCE(4), .CNT_W(16), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .settled(settled), .glitch_cnt(glitch_cnt)
  );

  tt_islam_ihfaz_debounce #(.N(2), .DEBOUNCE(1), .CNT_W(4), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .ena(ena1), .raw_in(raw1), .clean_out(clean1),
    .rise_pulse(rise1), .fall_pulse(fall1), .settled(settled1), .glitch_cnt(glitch1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] acc;
  int         nf;

  initial begin
    rst_n = 1'b0; ena = 1'b1; raw_in = 2'b00;
    rst1_n = 1'b0; ena1 = 1'b1; raw1 = 2'b00;
    tick(); tick();
    chk("rst_clean",   32'(clean_out),  0);
    chk("rst_rise",    32'(rise_pulse), 0);
    chk("rst_fall",    32'(fall_pulse), 0);
    chk("rst_glitch",  32'(glitch_cnt), 0);
    chk("rst_settled", 32'(settled),    1);

    // single rising channel, flip lands on edge 6
    rst_n = 1'b1; tick(); tick();
    raw_in = 2'b01;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("t1_clean_e%0d", e), 32'(clean_out),  (e >= 6) ? 1 : 0);
      chk($sformatf("t1_rise_e%0d", e),  32'(rise_pulse), (e == 6) ? 1 : 0);
      if (e >= 3) chk($sformatf("t1_settled_e%0d", e), 32'(settled), (e == 6) ? 1 : 0);
    end
    tick();
    chk("t1_rise_once", 32'(rise_pulse), 0);

    // ch1 high for 3 cycles is one aborted attempt
    acc = 2'b00;
    raw_in = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) raw_in = 2'b01;
      tick();
      acc |= rise_pulse | fall_pulse;
    end
    chk("t2_glitch1", 32'(glitch_cnt), 1);
    chk("t2_clean",   32'(clean_out),  1);
    chk("t2_nopulse", 32'(acc),        0);

    repeat (300) begin
      raw_in = 2'b11;
      for (int k = 0; k < 8; k++) begin
        if (k == 3) raw_in = 2'b01;
        tick();
        acc |= rise_pulse | fall_pulse;
      end
    end
    chk("t2_sat",         32'(glitch_cnt), 255);
    chk("t2_sat_clean",   32'(clean_out),  1);
    chk("t2_sat_nopulse", 32'(acc),        0);

    rst_n = 1'b0; raw_in = 2'b00;
    tick(); tick();
    chk("t2_rst_glitch", 32'(glitch_cnt), 0);
    chk("t2_rst_clean",  32'(clean_out),  0);
    rst_n = 1'b1; tick(); tick();

    // simultaneous glitch on both channels, then simultaneous toggle
    acc = 2'b00;
    raw_in = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) raw_in = 2'b00;
      tick();
      acc |= rise_pulse | fall_pulse;
    end
    chk("t3_glitch2",  32'(glitch_cnt), 2);
    chk("t3_nopulse",  32'(acc),        0);
    chk("t3_clean",    32'(clean_out),  0);
    raw_in = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("t3_rise_e5", 32'(rise_pulse), 0);
      if (e == 6) begin
        chk("t3_rise_e6",  32'(rise_pulse), 3);
        chk("t3_clean_e6", 32'(clean_out),  3);
      end
    end
    tick();
    chk("t3_rise_once", 32'(rise_pulse), 0);

    // falling edge on ch0
    raw_in = 2'b10;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("t4_fall_e5", 32'(fall_pulse), 0);
      if (e == 6) begin
        chk("t4_fall_e6",  32'(fall_pulse), 1);
        chk("t4_clean_e6", 32'(clean_out),  2);
        chk("t4_rise_e6",  32'(rise_pulse), 0);
      end
    end
    tick();
    raw_in = 2'b11;
    repeat (7) tick();
    chk("t4_restore", 32'(clean_out), 3);

    // bounce: low 2, high 1, then low -> fall 6 edges after the final low
    nf = 0;
    raw_in = 2'b10;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) raw_in = 2'b11;
      if (e == 4) raw_in = 2'b10;
      tick();
      if (fall_pulse[0]) nf++;
      if (e == 9) chk("t4_bounce_fall_e9", 32'(fall_pulse), 1);
    end
    chk("t4_bounce_count",  nf,                1);
    chk("t4_bounce_glitch", 32'(glitch_cnt),   3);
    chk("t4_bounce_clean",  32'(clean_out),    2);

    // ena low mid-WAIT freezes everything
    raw_in = 2'b11;
    repeat (4) tick();
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t5_hold_rise_%0d", k),    32'(rise_pulse), 0);
      chk($sformatf("t5_hold_clean_%0d", k),   32'(clean_out),  2);
      chk($sformatf("t5_hold_settled_%0d", k), 32'(settled),    0);
    end
    ena = 1'b1;
    tick();
    chk("t5_resume1_rise",  32'(rise_pulse), 0);
    chk("t5_resume1_clean", 32'(clean_out),  2);
    tick();
    chk("t5_resume2_rise",    32'(rise_pulse), 1);
    chk("t5_resume2_clean",   32'(clean_out),  3);
    chk("t5_resume2_settled", 32'(settled),    1);

    // reset mid-WAIT, then a normal flip after release
    rst_n = 1'b0; raw_in = 2'b00;
    tick(); tick();
    rst_n = 1'b1; tick(); tick();
    raw_in = 2'b01;
    repeat (4) tick();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("t6_rst_rise_%0d", k),    32'(rise_pulse), 0);
      chk($sformatf("t6_rst_clean_%0d", k),   32'(clean_out),  0);
      chk($sformatf("t6_rst_settled_%0d", k), 32'(settled),    1);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("t6_rise_e5", 32'(rise_pulse), 0);
      if (e == 6) begin
        chk("t6_rise_e6",  32'(rise_pulse), 1);
        chk("t6_clean_e6", 32'(clean_out),  1);
      end
    end

    // DEBOUNCE=1 instance flips on the first compare edge
    chk("t7_rst_settled", 32'(settled1), 1);
    chk("t7_rst_clean",   32'(clean1),   0);
    rst1_n = 1'b1; tick();
    raw1 = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("t7_clean_e%0d", e), 32'(clean1), (e >= 3) ? 1 : 0);
      chk($sformatf("t7_rise_e%0d", e),  32'(rise1),  (e == 3) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
